cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic_pkg.sv | 34 +++
 rtl/cond_logic_check.sv | 45 ++++
 rtl/cond_logic.sv | 96 +++++++++
 tb/tb_cond_logic.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_logic_pkg.sv
// Shared encodings for the ARM conditional-execution path: condition
// field values, NZCV bit positions and FlagW request bit positions.
package cond_logic_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Bit positions inside FlagW
   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_check.sv
// Pure combinational evaluation of an ARM condition field against the
// registered NZCV flags. NV (4'b1111) is treated as never-execute.
module cond_check
   import cond_logic_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = Flags[FLAG_N];
   assign w_z = Flags[FLAG_Z];
   assign w_c = Flags[FLAG_C];
   assign w_v = Flags[FLAG_V];

   // Decode the condition field into a single execute/skip decision
   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         COND_EQ: CondEx = w_z;
         COND_NE: CondEx = ~w_z;
         COND_CS: CondEx = w_c;
         COND_CC: CondEx = ~w_c;
         COND_MI: CondEx = w_n;
         COND_PL: CondEx = ~w_n;
         COND_VS: CondEx = w_v;
         COND_VC: CondEx = ~w_v;
         COND_HI: CondEx = w_c & ~w_z;
         COND_LS: CondEx = ~w_c | w_z;
         COND_GE: CondEx = (w_n == w_v);
         COND_LT: CondEx = (w_n != w_v);
         COND_GT: CondEx = ~w_z & (w_n == w_v);
         COND_LE: CondEx = w_z | (w_n != w_v);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flag register, gates the
// decoder's write requests with the evaluated condition, and counts
// executed versus condition-failed instructions with saturating counters.
// Flags written on an edge only influence CondEx from the next cycle on;
// there is deliberately no ALUFlags bypass.
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             InstrValid,
   input  logic             Stall,
   input  logic             CntClr,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SkipCnt
);

   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_exec_cnt;
   logic [CNT_W-1:0] r_skip_cnt;

   logic             w_cond_ex;
   logic             w_gated;
   logic             w_advance;
   logic             w_flag_en;

   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (r_flags),
      .CondEx (w_cond_ex)
   );

   // An instruction that passed its condition and is not a bubble
   assign w_gated   = w_cond_ex & InstrValid;
   // A real instruction retiring this edge (drives counters)
   assign w_advance = ~Stall & InstrValid;
   // Flag register may load only for a retiring, condition-passed instruction
   assign w_flag_en = w_advance & w_cond_ex;

   assign CondEx   = w_cond_ex;
   assign PCSrc    = PCS  & w_gated;
   assign MemWrite = MemW & w_gated;
   assign RegWrite = RegW & w_gated & ~NoWrite;
   assign Flags    = r_flags;
   assign ExecCnt  = r_exec_cnt;
   assign SkipCnt  = r_skip_cnt;

   // Flag register: N,Z and C,V halves load independently on request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags <= RESET_FLAGS;
      end else if (w_flag_en) begin
         if (FlagW[FLAGW_NZ]) begin
            r_flags[FLAG_N] <= ALUFlags[FLAG_N];
            r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagW[FLAGW_CV]) begin
            r_flags[FLAG_C] <= ALUFlags[FLAG_C];
            r_flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   // Saturating event counters; clear wins over increment and ignores Stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_exec_cnt <= '0;
         r_skip_cnt <= '0;
      end else if (CntClr) begin
         r_exec_cnt <= '0;
         r_skip_cnt <= '0;
      end else if (w_advance) begin
         if (w_cond_ex) begin
            if (r_exec_cnt != {CNT_W{1'b1}}) r_exec_cnt <= r_exec_cnt + CNT_W'(1);
         end else begin
            if (r_skip_cnt != {CNT_W{1'b1}}) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed scenarios followed by random traffic,
// all compared against a behavioural model of flags and counters.
// A narrow counter width keeps saturation reachable in a few hundred cycles.
module tb_cond_logic;

   localparam logic [3:0] RST_FLAGS = 4'b0010;
   localparam int         CW        = 8;
   localparam int         CNT_MAX   = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0]    Cond;
   logic [3:0]    ALUFlags;
   logic [1:0]    FlagW;
   logic          PCS, RegW, MemW, NoWrite, InstrValid, Stall, CntClr;
   logic          PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]    Flags;
   logic [CW-1:0] ExecCnt, SkipCnt;

   cond_logic #(.RESET_FLAGS(RST_FLAGS), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .NoWrite    (NoWrite),
      .InstrValid (InstrValid),
      .Stall      (Stall),
      .CntClr     (CntClr),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .CondEx     (CondEx),
      .Flags      (Flags),
      .ExecCnt    (ExecCnt),
      .SkipCnt    (SkipCnt)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fails  = 0;

   logic [3:0] m_flags;
   int         m_exec;
   int         m_skip;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ARM encoding: bits [3:1] pick a predicate, bit 0 inverts it (except AL/NV)
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, p;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: p = z;
         3'd1: p = cy;
         3'd2: p = n;
         3'd3: p = v;
         3'd4: p = cy & ~z;
         3'd5: p = (n == v);
         3'd6: p = ~z & (n == v);
         default: p = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return p ^ c[0];
   endfunction

   task automatic model_reset();
      m_flags = RST_FLAGS;
      m_exec  = 0;
      m_skip  = 0;
   endtask

   // Compare every output against the model for the current inputs
   task automatic check_outputs(input string tag);
      logic ce;
      ce = model_cond(Cond, m_flags);
      check({tag, ".condex"},   32'(CondEx),   32'(ce));
      check({tag, ".pcsrc"},    32'(PCSrc),    32'(PCS & ce & InstrValid));
      check({tag, ".memwrite"}, 32'(MemWrite), 32'(MemW & ce & InstrValid));
      check({tag, ".regwrite"}, 32'(RegWrite), 32'(RegW & ce & InstrValid & ~NoWrite));
      check({tag, ".flags"},    32'(Flags),    32'(m_flags));
      check({tag, ".execcnt"},  32'(ExecCnt),  32'(m_exec));
      check({tag, ".skipcnt"},  32'(SkipCnt),  32'(m_skip));
   endtask

   // Model of one rising edge, from the inputs held across it
   task automatic model_edge();
      logic ce;
      ce = model_cond(Cond, m_flags);
      if (CntClr) begin
         m_exec = 0;
         m_skip = 0;
      end else if (!Stall && InstrValid) begin
         if (ce) m_exec = (m_exec < CNT_MAX) ? m_exec + 1 : m_exec;
         else    m_skip = (m_skip < CNT_MAX) ? m_skip + 1 : m_skip;
      end
      if (!Stall && InstrValid && ce) begin
         if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
         if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge: drive, check at the falling edge,
   // then let the next rising edge happen and update the model.
   task automatic drive(input string tag, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic regw,
                        input logic memw, input logic nowr, input logic iv,
                        input logic stall, input logic clr);
      Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw; MemW = memw;
      NoWrite = nowr; InstrValid = iv; Stall = stall; CntClr = clr;
      @(negedge clk);
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0;
      MemW = 1'b0; NoWrite = 1'b0; InstrValid = 1'b0; Stall = 1'b0; CntClr = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      // During reset CondEx must reflect RESET_FLAGS (C set -> CS true)
      Cond = 4'h2; PCS = 1'b1; InstrValid = 1'b1;
      #3;
      check_outputs("in_reset");
      @(posedge clk);
      #1;
      check_outputs("in_reset_edge");
      reset = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;

      // SUB 4-5: N set, counted as executed
      drive("sub_flags", 4'hE, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("sub_flags.value", 32'(Flags), 32'h8);
      check("sub_flags.exec1", 32'(ExecCnt), 32'd1);
      // LT passes, GE fails with N=1,V=0
      drive("lt_pass", 4'hB, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive("ge_fail", 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ge_fail.skip1", 32'(SkipCnt), 32'd1);

      // Clear flags, then partial update of N,Z only
      drive("flags_zero", 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive("nz_only",    4'hE, 4'b0111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("nz_only.value", 32'(Flags), 32'h4);
      // Z=1 now, so EQ passes; use NE to show a failed condition cannot write
      drive("ne_blocked", 4'h1, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ne_blocked.value", 32'(Flags), 32'h4);
      // Flags written this cycle do not bypass into CondEx
      drive("no_bypass", 4'h0, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive("after_wr",  4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Compare-class op: RegWrite suppressed, flags still written
      drive("nowrite", 4'hE, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("nowrite.value", 32'(Flags), 32'h6);
      // Three stalled cycles with write requests pending
      for (int i = 0; i < 3; i++)
         drive("stall", 4'hE, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      // Bubbles: no enables, no updates
      drive("bubble", 4'hE, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Exec counter saturation
      drive("clr", 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < CNT_MAX + 3; i++)
         drive("exec_sat", 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("exec_sat.max", 32'(ExecCnt), 32'(CNT_MAX));
      // Skip counter saturation via NV
      for (int i = 0; i < CNT_MAX + 3; i++)
         drive("skip_sat", 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("skip_sat.max", 32'(SkipCnt), 32'(CNT_MAX));
      // Clear while stalled, clear beats an increment request
      drive("clr_stall", 4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive("clr_inc",   4'hE, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("clr.exec0", 32'(ExecCnt), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         drive("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));

      // Async reset between edges with flags all set
      drive("set_all", 4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive("cnt_one", 4'hE, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // Hold a flag write request and a stall across the reset
      Cond = 4'hF; ALUFlags = 4'b1100; FlagW = 2'b11; InstrValid = 1'b1; Stall = 1'b1;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_outputs("async_rst");
      Cond = 4'hE; Stall = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("rst_vs_write");
      #2;
      reset = 1'b0;
      @(negedge clk);
      check_outputs("post_rst");
      @(posedge clk);
      model_edge();
      #1;
      check("post_rst.first_wr", 32'(Flags), 32'hC);
      drive("final", 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
